// File: rtl/bcd_conv_sched_if.sv
// Requester/result handshake bundle for the shared binary-to-BCD engine.
// The engine uses the slave modport; the client side uses master.
interface bcd_conv_sched_if #(
  parameter int BIN_W  = 8,
  parameter int DIGITS = 3
);
  logic                  a_valid;
  logic [BIN_W-1:0]      a_bin;
  logic                  a_ready;
  logic                  b_valid;
  logic [BIN_W-1:0]      b_bin;
  logic                  b_ready;
  logic                  out_valid;
  logic [4*DIGITS-1:0]   out_bcd;
  logic                  out_id;
  logic                  out_ready;
  logic                  busy;

  modport master (
    output a_valid, a_bin, b_valid, b_bin, out_ready,
    input  a_ready, b_ready, out_valid, out_bcd, out_id, busy
  );

  modport slave (
    input  a_valid, a_bin, b_valid, b_bin, out_ready,
    output a_ready, b_ready, out_valid, out_bcd, out_id, busy
  );
endinterface

// File: rtl/bcd_conv_sched.sv
// Shared iterative double-dabble converter with round-robin arbitration
// between requesters A and B; one adjust or shift step per clock.
module bcd_conv_sched #(
  parameter int BIN_W  = 8,
  parameter int DIGITS = 3
) (
  input  logic              clk,
  input  logic              rst,
  bcd_conv_sched_if.slave   bus
);
  localparam int BW = 4 * DIGITS;
  localparam int SW = BW + BIN_W;
  localparam int CW = $clog2(BIN_W + 1);

  typedef enum logic [1:0] {IDLE, ADJ, SHIFT, DONE} state_t;

  state_t          state, state_nxt;
  logic [SW-1:0]   sr, sr_adj, sr_shl;
  logic [CW-1:0]   cnt;
  logic            ptr;
  logic            id;
  logic            out_valid_r;
  logic [BW-1:0]   out_bcd_r;
  logic            grant_a, grant_b;

  // Both readies cannot be high with both valids: that would need ptr to be A and B at once.
  always_comb begin
    bus.a_ready = (state == IDLE) && (!ptr || !bus.b_valid);
    bus.b_ready = (state == IDLE) && ( ptr || !bus.a_valid);
    grant_a     = bus.a_ready && bus.a_valid;
    grant_b     = bus.b_ready && bus.b_valid;
    state_nxt   = state;
    case (state)
      IDLE:    if (grant_a || grant_b) state_nxt = ADJ;
      ADJ:     state_nxt = SHIFT;
      SHIFT:   state_nxt = (cnt == CW'(1)) ? DONE : ADJ;
      DONE:    if (bus.out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    sr_adj = sr;
    for (int unsigned d = 0; d < DIGITS; d++) begin
      if (sr[BIN_W + 4*d +: 4] >= 4'd5)
        sr_adj[BIN_W + 4*d +: 4] = sr[BIN_W + 4*d +: 4] + 4'd3;
    end
    sr_shl = {sr[SW-2:0], 1'b0};
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sr          <= '0;
      cnt         <= '0;
      ptr         <= 1'b0;
      id          <= 1'b0;
      out_valid_r <= 1'b0;
      out_bcd_r   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_a) begin
            sr  <= {{BW{1'b0}}, bus.a_bin};
            id  <= 1'b0;
            cnt <= CW'(BIN_W);
            ptr <= 1'b1;
          end else if (grant_b) begin
            sr  <= {{BW{1'b0}}, bus.b_bin};
            id  <= 1'b1;
            cnt <= CW'(BIN_W);
            ptr <= 1'b0;
          end
        end
        ADJ: sr <= sr_adj;
        SHIFT: begin
          sr  <= sr_shl;
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            out_bcd_r   <= sr_shl[SW-1 -: BW];
            out_valid_r <= 1'b1;
          end
        end
        DONE: if (bus.out_ready) out_valid_r <= 1'b0;
        default: ;
      endcase
    end
  end

  assign bus.out_valid = out_valid_r;
  assign bus.out_bcd   = out_bcd_r;
  assign bus.out_id    = id;
  assign bus.busy      = (state != IDLE);
endmodule

// File: tb/tb_bcd_conv_sched.sv
// Directed bench for bcd_conv_sched: conversions, arbitration, backpressure, reset.
module tb_bcd_conv_sched;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;

  bcd_conv_sched_if #(.BIN_W(8), .DIGITS(3)) bus ();
  bcd_conv_sched #(.BIN_W(8), .DIGITS(3)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  task automatic do_reset();
    bus.a_valid = 1'b0; bus.a_bin = '0;
    bus.b_valid = 1'b0; bus.b_bin = '0;
    bus.out_ready = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // Issue one operand, wait for its result and consume it; returns observations only.
  task automatic run_one(input logic who, input logic [7:0] v,
                         output logic [11:0] bcd, output logic rid,
                         output int lat, output logic busy_drop);
    int w = 0;
    @(negedge clk);
    if (who) begin bus.b_valid = 1'b1; bus.b_bin = v; end
    else     begin bus.a_valid = 1'b1; bus.a_bin = v; end
    #1;
    while (!(who ? bus.b_ready : bus.a_ready) && w < 40) begin
      @(negedge clk); #1; w++;
    end
    @(posedge clk); #1;
    bus.a_valid = 1'b0; bus.b_valid = 1'b0;
    busy_drop = 1'b0; lat = 0;
    @(negedge clk);
    while (!bus.out_valid && lat < 40) begin
      if (!bus.busy) busy_drop = 1'b1;
      @(negedge clk); lat++;
    end
    bcd = bus.out_bcd; rid = bus.out_id;
    bus.out_ready = 1'b1;
    @(posedge clk); #1 bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    logic [11:0] bcd; logic rid; int lat; logic bd;
    do_reset();
    @(negedge clk);
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid); end
    checks++; if (bus.out_bcd !== 12'h000) begin failures++; $display("FAIL reset_out_bcd got=%h exp=000", bus.out_bcd); end
    checks++; if (bus.out_id !== 1'b0) begin failures++; $display("FAIL reset_out_id got=%b exp=0", bus.out_id); end
    bus.a_valid = 1'b1; bus.a_bin = 8'd255; #1;
    checks++; if (bus.a_ready !== 1'b1) begin failures++; $display("FAIL reset_a_ready got=%b exp=1", bus.a_ready); end
    bus.a_valid = 1'b0; #1;
    run_one(1'b0, 8'd255, bcd, rid, lat, bd);
    checks++; if (bcd !== 12'h255) begin failures++; $display("FAIL conv255_bcd got=%h exp=255", bcd); end
    checks++; if (rid !== 1'b0) begin failures++; $display("FAIL conv255_id got=%b exp=0", rid); end
    checks++; if (lat !== 16) begin failures++; $display("FAIL conv255_latency got=%0d exp=16", lat); end
    checks++; if (bd !== 1'b0) begin failures++; $display("FAIL conv255_busy got_drop=%b exp=0", bd); end
  endtask

  task automatic test_values();
    logic [7:0]  vin [6] = '{8'd0, 8'd9, 8'd10, 8'd99, 8'd100, 8'd128};
    logic [11:0] vexp[6] = '{12'h000, 12'h009, 12'h010, 12'h099, 12'h100, 12'h128};
    logic [11:0] bcd; logic rid; int lat; logic bd;
    do_reset();
    for (int i = 0; i < 6; i++) begin
      run_one(1'b0, vin[i], bcd, rid, lat, bd);
      checks++; if (bcd !== vexp[i]) begin failures++; $display("FAIL values_bcd in=%0d got=%h exp=%h", vin[i], bcd, vexp[i]); end
      checks++; if (rid !== 1'b0) begin failures++; $display("FAIL values_id in=%0d got=%b exp=0", vin[i], rid); end
    end
  endtask

  task automatic test_round_robin();
    logic        ids [4];
    logic [11:0] bcds[4];
    logic        exp_id[4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic [11:0] exp_bcd[4] = '{12'h042, 12'h007, 12'h042, 12'h007};
    int n = 0; int cyc = 0; logic both = 1'b0;
    do_reset();
    bus.a_bin = 8'd42; bus.b_bin = 8'd7;
    bus.a_valid = 1'b1; bus.b_valid = 1'b1; bus.out_ready = 1'b1;
    while (n < 4 && cyc < 200) begin
      @(negedge clk); #1; cyc++;
      if (bus.a_ready && bus.b_ready) both = 1'b1;
      if (bus.out_valid) begin ids[n] = bus.out_id; bcds[n] = bus.out_bcd; n++; end
    end
    bus.a_valid = 1'b0; bus.b_valid = 1'b0; bus.out_ready = 1'b0;
    checks++; if (n !== 4) begin failures++; $display("FAIL rr_count got=%0d exp=4", n); end
    for (int i = 0; i < n; i++) begin
      checks++; if (ids[i] !== exp_id[i]) begin failures++; $display("FAIL rr_id idx=%0d got=%b exp=%b", i, ids[i], exp_id[i]); end
      checks++; if (bcds[i] !== exp_bcd[i]) begin failures++; $display("FAIL rr_bcd idx=%0d got=%h exp=%h", i, bcds[i], exp_bcd[i]); end
    end
    checks++; if (both !== 1'b0) begin failures++; $display("FAIL rr_both_ready got=%b exp=0", both); end
  endtask

  task automatic test_backpressure();
    int w = 0; logic [11:0] hold_bcd; logic hold_id; logic bad = 1'b0;
    do_reset();
    @(negedge clk); bus.a_valid = 1'b1; bus.a_bin = 8'd100;
    @(posedge clk); #1 bus.a_valid = 1'b0;
    @(negedge clk);
    while (!bus.out_valid && w < 40) begin @(negedge clk); w++; end
    checks++; if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL bp_valid got=%b exp=1", bus.out_valid); end
    hold_bcd = 12'h100; hold_id = 1'b0;
    bus.a_valid = 1'b1; bus.b_valid = 1'b1; bus.b_bin = 8'd77; #1;
    for (int i = 0; i < 5; i++) begin
      if (bus.out_bcd !== hold_bcd || bus.out_id !== hold_id || bus.out_valid !== 1'b1 ||
          bus.a_ready !== 1'b0 || bus.b_ready !== 1'b0 || bus.busy !== 1'b1) bad = 1'b1;
      @(negedge clk); #1;
    end
    checks++; if (bad !== 1'b0) begin failures++; $display("FAIL bp_hold got_bad=%b exp=0", bad); end
    bus.out_ready = 1'b1;
    @(posedge clk); #1 bus.out_ready = 1'b0;
    @(negedge clk); #1;
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL bp_release_valid got=%b exp=0", bus.out_valid); end
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL bp_idle_busy got=%b exp=0", bus.busy); end
    checks++; if (bus.b_ready !== 1'b1 || bus.a_ready !== 1'b0) begin failures++; $display("FAIL bp_next_grant got_a=%b got_b=%b exp_a=0 exp_b=1", bus.a_ready, bus.b_ready); end
    @(posedge clk); #1 bus.a_valid = 1'b0; bus.b_valid = 1'b0;
    @(negedge clk);
    checks++; if (bus.busy !== 1'b1) begin failures++; $display("FAIL bp_next_accept got=%b exp=1", bus.busy); end
  endtask

  task automatic test_reset_mid();
    logic [11:0] bcd; logic rid; int lat; logic bd; logic leak = 1'b0;
    do_reset();
    @(negedge clk); bus.a_valid = 1'b1; bus.a_bin = 8'd255;
    @(posedge clk); #1 bus.a_valid = 1'b0;
    repeat (6) @(negedge clk);
    rst = 1'b1;
    @(negedge clk); #1;
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL midrst_busy got=%b exp=0", bus.busy); end
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL midrst_valid got=%b exp=0", bus.out_valid); end
    checks++; if (bus.a_ready !== 1'b1) begin failures++; $display("FAIL midrst_idle got_a_ready=%b exp=1", bus.a_ready); end
    rst = 1'b0;
    for (int i = 0; i < 40; i++) begin @(negedge clk); if (bus.out_valid) leak = 1'b1; end
    checks++; if (leak !== 1'b0) begin failures++; $display("FAIL midrst_no_result got=%b exp=0", leak); end
    run_one(1'b1, 8'd200, bcd, rid, lat, bd);
    checks++; if (bcd !== 12'h200) begin failures++; $display("FAIL midrst_bcd got=%h exp=200", bcd); end
    checks++; if (rid !== 1'b1) begin failures++; $display("FAIL midrst_id got=%b exp=1", rid); end
  endtask

  task automatic test_back_to_back();
    int t[3]; int n = 0; int cyc = 0; logic miss = 1'b0;
    do_reset();
    bus.b_bin = 8'd3; bus.b_valid = 1'b1; bus.out_ready = 1'b1;
    while (n < 3 && cyc < 100) begin
      @(negedge clk); #1; cyc++;
      if (!bus.busy && !bus.b_ready) miss = 1'b1;
      if (bus.b_valid && bus.b_ready) begin t[n] = cyc; n++; end
    end
    bus.b_valid = 1'b0; bus.out_ready = 1'b0;
    checks++; if (n !== 3) begin failures++; $display("FAIL b2b_count got=%0d exp=3", n); end
    checks++; if (miss !== 1'b0) begin failures++; $display("FAIL b2b_b_ready_idle got_miss=%b exp=0", miss); end
    if (n == 3) begin
      checks++; if (t[1] - t[0] !== 18) begin failures++; $display("FAIL b2b_interval1 got=%0d exp=18", t[1] - t[0]); end
      checks++; if (t[2] - t[1] !== 18) begin failures++; $display("FAIL b2b_interval2 got=%0d exp=18", t[2] - t[1]); end
    end
  endtask

  initial begin
    test_reset();
    test_values();
    test_round_robin();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
